exec_controller: RTL and testbench
==================================

# exec_controller

Execution sequencer for the pipelined MIPS core under debugger control. It converts debugger commands (halt, single-step, free-run, run-N) into the global pipeline stall and a fetch-freeze. It detects the program's halt instruction at fetch and drains the pipeline before reporting completion. It also counts executed cycles for readout over UART, and sits between the debugger command decoder and the pipeline's stall/enable inputs.

## Interface
Parameters:
- SIZE, 32, instruction width
- CNT_WIDTH, 16, width of the run-N step counter
- HALT_OPCODE, 6'b111111, opcode field [31:26] that marks program end
- DRAIN_CYCLES, 4, unstalled cycles after halt fetch needed to retire in-flight instructions

Ports:
- i_clk  in  1  system clock, rising edge
- i_rst  in  1  asynchronous, active-low reset
- i_cmd_valid  in  1  command strobe
- o_cmd_ready  out  1  command can be accepted this cycle
- i_cmd  in  2  00 HALT, 01 STEP, 10 RUN, 11 RUN_N
- i_step_count  in  CNT_WIDTH  cycle budget for RUN_N, sampled on acceptance
- i_clear  in  1  return to IDLE and zero the cycle counter
- i_load_active  in  1  instruction memory being written by the debugger
- i_instr_if  in  SIZE  instruction at IF output
- o_stall  out  1  global pipeline stall
- o_freeze_fetch  out  1  holds PC/IF while later stages advance
- o_done  out  1  one-cycle pulse on entering HALTED
- o_state  out  3  IDLE=0, RUN=1, RUN_N=2, STEP=3, DRAIN=4, HALTED=5
- o_cycle_count  out  32  unstalled cycles since last clear, saturating

## Operation
- Command handshake: a command is accepted when i_cmd_valid && o_cmd_ready at a rising edge.
- o_cmd_ready is asserted in IDLE, RUN and RUN_N. It is forced to 0 when i_clear or i_load_active is high.
- IDLE: o_stall=1.
  - STEP goes to STEP.
  - RUN goes to RUN.
  - RUN_N loads remain=i_step_count and goes to RUN_N. If i_step_count==0, the command is accepted and the state stays IDLE.
  - HALT is accepted with no effect.
- STEP: o_stall=0 for exactly one cycle, then IDLE.
- RUN: o_stall=0 every cycle.
  - An accepted HALT goes to IDLE.
  - Accepted STEP/RUN/RUN_N commands are dropped.
- RUN_N: o_stall=0 and remain decrements every cycle.
  - On the cycle with remain==1, the next state is IDLE.
  - HALT goes to IDLE and clears remain.
- Halt detection (STEP, RUN, RUN_N): if i_instr_if[31:26]==HALT_OPCODE in an unstalled cycle, the next state is DRAIN.
  - Halt detection has priority over budget expiry and over an accepted HALT command.
- DRAIN: o_stall=0 and o_freeze_fetch=1 for DRAIN_CYCLES cycles (internal down-counter), then HALTED.
- HALTED: o_stall=1, o_freeze_fetch=0, o_cmd_ready=0. The state is left only via i_clear or reset.
- o_done pulses on the first HALTED cycle.
- o_cycle_count increments on every cycle with o_stall==0, DRAIN cycles included. It saturates at 32'hFFFFFFFF.
- Priority, highest first: reset, i_load_active, i_clear, halt detection, command.
  - i_load_active forces IDLE and o_stall=1 and keeps the counter.
  - i_clear forces IDLE and zeroes o_cycle_count and remain.

## Timing
- All outputs are registered or decoded from registered state only. There are no combinational paths from any input to any output.
- Reset values: state IDLE, o_stall=1, o_freeze_fetch=0, o_done=0, o_cmd_ready=1, o_cycle_count=0, remain=0, drain counter=0.
- Command latency: accepted at edge k, o_stall falls after edge k.
  - STEP gives exactly one o_stall=0 cycle.
  - RUN_N with N gives exactly N o_stall=0 cycles, then o_stall=1.
- HALT command latency: o_stall rises after the acceptance edge. No further unstalled cycle follows acceptance.
- Halt detection at edge k: o_freeze_fetch=1 for cycles k+1 through k+DRAIN_CYCLES, and o_stall stays 0 over that window. HALTED and o_done=1 follow in the next cycle.
- Reset asserted mid-DRAIN or mid-RUN_N: all state returns immediately to reset values. No o_done is issued.
- i_load_active deasserting leaves the block in IDLE. It waits for a new command.

## Test plan
- Reset, then STEP: exactly one cycle with o_stall=0. o_cycle_count=1, state returns to IDLE.
- RUN_N with i_step_count=5: five consecutive o_stall=0 cycles, then stall. o_cycle_count=5. Repeat with i_step_count=0: no unstalled cycle, count unchanged.
- RUN, HALTED-free program, then HALT after 10 cycles: o_stall rises on the edge after acceptance. o_cycle_count=10, o_cmd_ready stays 1.
- RUN with i_instr_if=32'hFC000000 after 3 cycles: 4 cycles with o_freeze_fetch=1 and o_stall=0, then HALTED with a one-cycle o_done. o_cycle_count=7 (3 + 4 drain), o_cmd_ready=0; i_clear returns IDLE with count 0.
- Halt opcode on the last RUN_N cycle, with a HALT command in the same cycle: DRAIN entered, budget expiry and command both ignored.
- i_load_active pulsed during RUN_N (remain=3): immediate IDLE with o_stall=1 and o_cmd_ready=0 while high; o_cycle_count retained. Async reset mid-DRAIN: all outputs at reset values before the next edge, no o_done.

Source files
------------

// File: rtl/exec_controller.sv
// exec_controller
// Execution sequencer between the debugger command decoder and the pipeline.
// Turns HALT / STEP / RUN / RUN_N commands into the global stall and a fetch
// freeze. Watches IF for the program-end opcode, drains the pipeline, then
// parks in HALTED. Counts unstalled cycles for UART readout.
//
// Ports
//   i_clk            system clock, rising edge
//   i_rst            asynchronous reset, active low
//   i_cmd_valid      command strobe
//   o_cmd_ready      command can be accepted this cycle
//   i_cmd            00 HALT, 01 STEP, 10 RUN, 11 RUN_N
//   i_step_count     cycle budget for RUN_N, sampled on acceptance
//   i_clear          return to IDLE, zero the cycle counter
//   i_load_active    debugger is writing instruction memory
//   i_instr_if       instruction at IF output
//   o_stall          global pipeline stall
//   o_freeze_fetch   hold PC/IF while later stages advance
//   o_done           one-cycle pulse on entering HALTED
//   o_state          current state code
//   o_cycle_count    unstalled cycles since last clear, saturating
//
// State   | meaning
// IDLE    | pipeline stalled, waiting for a command
// RUN     | free-running until HALT command or halt opcode
// RUN_N   | running for a fixed number of cycles
// STEP    | single unstalled cycle
// DRAIN   | halt opcode fetched, fetch frozen while in-flight ops retire
// HALTED  | program finished; left only through i_clear or reset

module exec_controller #(
    parameter int         SIZE         = 32,
    parameter int         CNT_WIDTH    = 16,
    parameter logic [5:0] HALT_OPCODE  = 6'b111111,
    parameter int         DRAIN_CYCLES = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic [1:0]           i_cmd,
    input  logic [CNT_WIDTH-1:0] i_step_count,
    input  logic                 i_clear,
    input  logic                 i_load_active,
    input  logic [SIZE-1:0]      i_instr_if,
    output logic                 o_stall,
    output logic                 o_freeze_fetch,
    output logic                 o_done,
    output logic [2:0]           o_state,
    output logic [31:0]          o_cycle_count
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_RUN_N  = 3'd2,
        ST_STEP   = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_HALTED = 3'd5
    } state_t;

    localparam logic [1:0] CMD_HALT  = 2'b00;
    localparam logic [1:0] CMD_STEP  = 2'b01;
    localparam logic [1:0] CMD_RUN   = 2'b10;
    localparam logic [1:0] CMD_RUN_N = 2'b11;

    localparam int             DW         = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0]  DRAIN_LOAD = DW'(DRAIN_CYCLES);

    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] remain, remain_nxt;
    logic [DW-1:0]        drain_cnt, drain_nxt;

    logic accept;
    logic halt_seen;
    logic load_eff;
    logic clear_eff;

    // HALTED ignores i_load_active: only clear or reset may leave it.
    assign load_eff  = i_load_active && (state != ST_HALTED);
    assign clear_eff = i_clear && !load_eff;
    assign accept    = i_cmd_valid && o_cmd_ready && !i_clear && !i_load_active;
    assign halt_seen = ((state == ST_RUN) || (state == ST_RUN_N) || (state == ST_STEP))
                       && (i_instr_if[SIZE-1:SIZE-6] == HALT_OPCODE);
    assign o_state   = state;

    always_comb begin
        state_nxt  = state;
        remain_nxt = remain;
        drain_nxt  = drain_cnt;
        if (load_eff) begin
            state_nxt = ST_IDLE;
            drain_nxt = '0;
        end else if (clear_eff) begin
            state_nxt  = ST_IDLE;
            remain_nxt = '0;
            drain_nxt  = '0;
        end else if (halt_seen) begin
            // Halt opcode beats both budget expiry and a same-cycle HALT command.
            state_nxt = ST_DRAIN;
            drain_nxt = DRAIN_LOAD;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (i_cmd)
                            CMD_STEP: state_nxt = ST_STEP;
                            CMD_RUN:  state_nxt = ST_RUN;
                            CMD_RUN_N: begin
                                remain_nxt = i_step_count;
                                if (i_step_count != '0) state_nxt = ST_RUN_N;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    if (accept && (i_cmd == CMD_HALT)) state_nxt = ST_IDLE;
                end
                ST_RUN_N: begin
                    if (accept && (i_cmd == CMD_HALT)) begin
                        state_nxt  = ST_IDLE;
                        remain_nxt = '0;
                    end else begin
                        remain_nxt = remain - CNT_WIDTH'(1);
                        if (remain <= CNT_WIDTH'(1)) state_nxt = ST_IDLE;
                    end
                end
                ST_STEP: state_nxt = ST_IDLE;
                ST_DRAIN: begin
                    drain_nxt = drain_cnt - DW'(1);
                    if (drain_cnt <= DW'(1)) state_nxt = ST_HALTED;
                end
                ST_HALTED: state_nxt = ST_HALTED;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state          <= ST_IDLE;
            remain         <= '0;
            drain_cnt      <= '0;
            o_stall        <= 1'b1;
            o_freeze_fetch <= 1'b0;
            o_done         <= 1'b0;
            o_cmd_ready    <= 1'b1;
            o_cycle_count  <= '0;
        end else begin
            state          <= state_nxt;
            remain         <= remain_nxt;
            drain_cnt      <= drain_nxt;
            o_stall        <= !((state_nxt == ST_RUN) || (state_nxt == ST_RUN_N) ||
                                (state_nxt == ST_STEP) || (state_nxt == ST_DRAIN));
            o_freeze_fetch <= (state_nxt == ST_DRAIN);
            o_done         <= (state_nxt == ST_HALTED) && (state != ST_HALTED);
            // Registered copy of the ready rule; clear/load mask it from the next cycle.
            o_cmd_ready    <= !i_clear && !i_load_active &&
                              ((state_nxt == ST_IDLE) || (state_nxt == ST_RUN) ||
                               (state_nxt == ST_RUN_N));
            if (clear_eff)
                o_cycle_count <= '0;
            else if (!o_stall && (o_cycle_count != 32'hFFFF_FFFF))
                o_cycle_count <= o_cycle_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_exec_controller.sv
// Testbench for exec_controller: directed scenarios with literal expectations
// plus a randomized run, all compared every cycle against a behavioural model.

module tb_exec_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd;
    logic [15:0] step_count;
    logic        clear;
    logic        load_active;
    logic [31:0] instr;
    logic        stall;
    logic        freeze;
    logic        done;
    logic [2:0]  state;
    logic [31:0] cycle_count;

    always #5 clk = ~clk;

    exec_controller dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_cmd_valid    (cmd_valid),
        .o_cmd_ready    (cmd_ready),
        .i_cmd          (cmd),
        .i_step_count   (step_count),
        .i_clear        (clear),
        .i_load_active  (load_active),
        .i_instr_if     (instr),
        .o_stall        (stall),
        .o_freeze_fetch (freeze),
        .o_done         (done),
        .o_state        (state),
        .o_cycle_count  (cycle_count)
    );

    int checks = 0;
    int errors = 0;

    // Model: mode codes follow the o_state numbering in the interface.
    int          m_mode;
    int          m_remain;
    int          m_drain;
    longint      m_count;
    bit          m_ready;
    bit          m_done;

    localparam logic [31:0] HALT_INSTR = 32'hFC00_0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_mode   = 0;
        m_remain = 0;
        m_drain  = 0;
        m_count  = 0;
        m_ready  = 1'b1;
        m_done   = 1'b0;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    function automatic void model_step();
        bit unst  = (m_mode >= 1) && (m_mode <= 4);
        bit acc   = cmd_valid && m_ready && !clear && !load_active;
        bit hseen = (m_mode >= 1) && (m_mode <= 3) && (instr[31:26] == 6'h3F);
        int prev  = m_mode;
        if (unst && (m_count < 64'hFFFF_FFFF)) m_count++;
        if (load_active && m_mode != 5) begin
            m_mode = 0;
        end else if (clear) begin
            m_mode   = 0;
            m_count  = 0;
            m_remain = 0;
        end else if (hseen) begin
            m_mode  = 4;
            m_drain = 4;
        end else begin
            case (m_mode)
                0: if (acc) begin
                    if (cmd == 2'b01) m_mode = 3;
                    else if (cmd == 2'b10) m_mode = 1;
                    else if (cmd == 2'b11 && step_count != 0) begin
                        m_mode   = 2;
                        m_remain = int'(step_count);
                    end
                end
                1: if (acc && cmd == 2'b00) m_mode = 0;
                2: if (acc && cmd == 2'b00) begin
                    m_mode   = 0;
                    m_remain = 0;
                end else begin
                    m_remain--;
                    if (m_remain == 0) m_mode = 0;
                end
                3: m_mode = 0;
                4: begin
                    m_drain--;
                    if (m_drain == 0) m_mode = 5;
                end
                default: ;
            endcase
        end
        m_done  = (m_mode == 5) && (prev != 5);
        m_ready = !load_active && !clear && (m_mode <= 2);
    endfunction

    task automatic compare_all();
        chk("state",  {29'd0, state}, 32'(m_mode));
        chk("stall",  {31'd0, stall}, {31'd0, !((m_mode >= 1) && (m_mode <= 4))});
        chk("freeze", {31'd0, freeze}, {31'd0, (m_mode == 4)});
        chk("done",   {31'd0, done}, {31'd0, m_done});
        chk("ready",  {31'd0, cmd_ready}, {31'd0, m_ready});
        chk("count",  cycle_count, m_count[31:0]);
    endtask

    // Called at a negedge: apply inputs, clock once, check after the edge.
    task automatic cyc(input bit v, input logic [1:0] c, input logic [15:0] n,
                       input bit cl, input bit ld, input logic [31:0] ins);
        cmd_valid   = v;
        cmd         = c;
        step_count  = n;
        clear       = cl;
        load_active = ld;
        instr       = ins;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(0, 2'b00, 16'd0, 0, 0, 32'd0);
    endtask

    initial begin
        rst = 1'b0; cmd_valid = 0; cmd = 0; step_count = 0;
        clear = 0; load_active = 0; instr = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        compare_all();
        chk("rst_stall", {31'd0, stall}, 32'd1);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);

        // STEP: exactly one unstalled cycle
        cyc(1, 2'b01, 16'd0, 0, 0, 32'd0);
        chk("step_unstalled", {31'd0, stall}, 32'd0);
        idle(1);
        chk("step_back_idle", {29'd0, state}, 32'd0);
        chk("step_count", cycle_count, 32'd1);

        // RUN_N 5 then RUN_N 0
        cyc(1, 2'b11, 16'd5, 0, 0, 32'd0);
        idle(4);
        chk("runn_still_running", {31'd0, stall}, 32'd0);
        idle(1);
        chk("runn_stalled", {31'd0, stall}, 32'd1);
        chk("runn_count", cycle_count, 32'd6);
        cyc(1, 2'b11, 16'd0, 0, 0, 32'd0);
        chk("runn0_state", {29'd0, state}, 32'd0);
        chk("runn0_count", cycle_count, 32'd6);

        // RUN then HALT command after 10 cycles
        cyc(0, 2'b00, 16'd0, 1, 0, 32'd0);
        chk("clear_count", cycle_count, 32'd0);
        idle(1);
        cyc(1, 2'b10, 16'd0, 0, 0, 32'd0);
        idle(9);
        cyc(1, 2'b00, 16'd0, 0, 0, 32'd0);
        chk("halt_cmd_stall", {31'd0, stall}, 32'd1);
        chk("halt_cmd_count", cycle_count, 32'd10);
        chk("halt_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // RUN, halt opcode on the third cycle, drain, HALTED
        cyc(0, 2'b00, 16'd0, 1, 0, 32'd0);
        idle(1);
        cyc(1, 2'b10, 16'd0, 0, 0, 32'd0);
        idle(2);
        cyc(0, 2'b00, 16'd0, 0, 0, HALT_INSTR);
        for (int i = 0; i < 4; i++) begin
            chk("drain_freeze", {31'd0, freeze}, 32'd1);
            chk("drain_stall", {31'd0, stall}, 32'd0);
            idle(1);
        end
        chk("halted_state", {29'd0, state}, 32'd5);
        chk("halted_done", {31'd0, done}, 32'd1);
        chk("halted_count", cycle_count, 32'd7);
        chk("halted_ready", {31'd0, cmd_ready}, 32'd0);
        chk("model_pin_count", m_count[31:0], 32'd7);
        idle(1);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        cyc(0, 2'b00, 16'd0, 1, 0, 32'd0);
        chk("clear_from_halted", {29'd0, state}, 32'd0);
        chk("clear_from_halted_cnt", cycle_count, 32'd0);

        // Halt opcode on last RUN_N cycle together with a HALT command
        idle(1);
        cyc(1, 2'b11, 16'd2, 0, 0, 32'd0);
        idle(1);
        cyc(1, 2'b00, 16'd0, 0, 0, HALT_INSTR);
        chk("prio_drain", {29'd0, state}, 32'd4);
        idle(4);
        chk("prio_halted", {29'd0, state}, 32'd5);
        cyc(0, 2'b00, 16'd0, 1, 0, 32'd0);
        idle(1);

        // i_load_active during RUN_N with remain=3
        cyc(1, 2'b11, 16'd5, 0, 0, 32'd0);
        idle(2);
        cyc(0, 2'b00, 16'd0, 0, 1, 32'd0);
        chk("load_idle", {29'd0, state}, 32'd0);
        chk("load_stall", {31'd0, stall}, 32'd1);
        chk("load_ready", {31'd0, cmd_ready}, 32'd0);
        chk("load_count", cycle_count, 32'd3);
        cyc(1, 2'b10, 16'd0, 0, 1, 32'd0);
        chk("load_hold", {29'd0, state}, 32'd0);
        idle(1);
        chk("load_release_ready", {31'd0, cmd_ready}, 32'd1);
        chk("load_release_state", {29'd0, state}, 32'd0);

        // Async reset mid-DRAIN
        cyc(1, 2'b10, 16'd0, 0, 0, 32'd0);
        cyc(0, 2'b00, 16'd0, 0, 0, HALT_INSTR);
        idle(2);
        #2 rst = 1'b0;
        #1;
        chk("arst_state", {29'd0, state}, 32'd0);
        chk("arst_stall", {31'd0, stall}, 32'd1);
        chk("arst_freeze", {31'd0, freeze}, 32'd0);
        chk("arst_count", cycle_count, 32'd0);
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        chk("arst_no_done", {31'd0, done}, 32'd0);
        compare_all();
        @(negedge clk);
        rst = 1'b1;

        // Randomized run
        for (int i = 0; i < 4000; i++) begin
            bit          v  = ($urandom_range(3) == 0);
            logic [1:0]  c  = 2'($urandom_range(3));
            logic [15:0] n  = 16'($urandom_range(9));
            bit          cl = ($urandom_range(60) == 0);
            bit          ld = ($urandom_range(50) == 0);
            logic [31:0] ins = $urandom;
            if ($urandom_range(20) == 0) ins[31:26] = 6'h3F;
            else if (ins[31:26] == 6'h3F) ins[31] = 1'b0;
            cyc(v, c, n, cl, ld, ins);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
